// File: rtl/echo_tof_detector_if.sv
// echo_tof_detector_if
//   Bundles the measurement-side signals of the echo time-of-flight detector.
//   master : the measurement controller / ADC front end. It drives start,
//            adc_valid, adc_data, threshold and tx_busy.
//   slave  : the detector. It drives echo_tof, echo_peak, timeout_flag,
//            processing_done and busy.
//   Clock and reset are not part of the bundle.
interface echo_tof_detector_if #(
    parameter int ADC_W = 12
);
    logic             start;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_data;
    logic [ADC_W-1:0] threshold;
    logic             tx_busy;
    logic [19:0]      echo_tof;
    logic [17:0]      echo_peak;
    logic             timeout_flag;
    logic             processing_done;
    logic             busy;

    modport master (
        output start, adc_valid, adc_data, threshold, tx_busy,
        input  echo_tof, echo_peak, timeout_flag, processing_done, busy
    );

    modport slave (
        input  start, adc_valid, adc_data, threshold, tx_busy,
        output echo_tof, echo_peak, timeout_flag, processing_done, busy
    );
endinterface

// File: rtl/echo_tof_detector.sv
// echo_tof_detector
//   Measures ultrasonic echo time-of-flight for one transmit burst. After a
//   start it counts clk_50M cycles, ignores the ring-down window, looks for
//   CONFIRM_N consecutive valid samples whose rectified magnitude exceeds the
//   latched threshold, then tracks the peak magnitude for PEAK_WIN clocks and
//   presents the result to the downstream UART packet transmitter.
// Ports
//   clk_50M  : system clock
//   rst_n    : asynchronous, active-low reset
//   bus      : echo_tof_detector_if.slave
//              inputs : start, adc_valid, adc_data, threshold, tx_busy
//              outputs: echo_tof (20 b, 20'hFFFFF on timeout), echo_peak
//                       (18 b), timeout_flag, processing_done (1-cycle
//                       strobe), busy (high in every state except IDLE)
module echo_tof_detector #(
    parameter int ADC_W        = 12,
    parameter int BLANK_CYCLES = 5000,
    parameter int TIMEOUT      = 1_000_000,
    parameter int CONFIRM_N    = 4,
    parameter int PEAK_WIN     = 64
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    echo_tof_detector_if.slave bus
);
    localparam int               PW_W        = (PEAK_WIN > 1) ? $clog2(PEAK_WIN) : 1;
    localparam logic [ADC_W-1:0] MID         = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [19:0]      BLANK_LAST  = 20'(BLANK_CYCLES - 1);
    localparam logic [19:0]      TIMEOUT_CNT = 20'(TIMEOUT);
    localparam logic [3:0]       RUN_LAST    = 4'(CONFIRM_N - 1);
    localparam logic [PW_W-1:0]  PW_LAST     = PW_W'(PEAK_WIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        SEARCH,
        CONFIRM,
        PEAK,
        DONE
    } state_t;

    state_t           state_q;
    logic [19:0]      tof_cnt_q;
    logic [19:0]      cand_tof_q;
    logic [ADC_W-1:0] thr_q;
    logic [ADC_W-1:0] peak_max_q;
    logic [3:0]       run_cnt_q;
    logic [PW_W-1:0]  win_cnt_q;
    logic [19:0]      echo_tof_q;
    logic [17:0]      echo_peak_q;
    logic             timeout_q;
    logic             busy_q;

    logic [ADC_W-1:0] mag;
    logic [ADC_W-1:0] peak_d;
    logic             qual;
    logic             at_timeout;
    logic             confirm_done;
    logic             counting;

    // Rectified magnitude around midscale (offset-binary input).
    assign mag = (bus.adc_data >= MID) ? (bus.adc_data - MID) : (MID - bus.adc_data);
    assign qual = bus.adc_valid && (mag > thr_q);

    // Running maximum including the sample presented this cycle.
    assign peak_d = (bus.adc_valid && (mag > peak_max_q)) ? mag : peak_max_q;

    assign at_timeout = (tof_cnt_q == TIMEOUT_CNT);
    assign counting   = (state_q == BLANK) || (state_q == SEARCH) ||
                        (state_q == CONFIRM) || (state_q == PEAK);

    // The sample that completes the run this cycle; it beats a simultaneous timeout.
    assign confirm_done = qual &&
                          (((state_q == SEARCH) && (CONFIRM_N == 1)) ||
                           ((state_q == CONFIRM) && (run_cnt_q == RUN_LAST)));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tof_cnt_q   <= '0;
            cand_tof_q  <= '0;
            thr_q       <= '0;
            peak_max_q  <= '0;
            run_cnt_q   <= '0;
            win_cnt_q   <= '0;
            echo_tof_q  <= '0;
            echo_peak_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Stamp counter: value during a cycle is the stamp of that cycle's sample.
            if (counting && (tof_cnt_q != 20'hFFFFF)) begin
                tof_cnt_q <= tof_cnt_q + 20'd1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        thr_q      <= bus.threshold;
                        tof_cnt_q  <= '0;
                        run_cnt_q  <= '0;
                        peak_max_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= BLANK;
                    end
                end

                BLANK: begin
                    if (tof_cnt_q == BLANK_LAST) begin
                        state_q <= SEARCH;
                    end
                end

                SEARCH, CONFIRM: begin
                    if (confirm_done) begin
                        if (state_q == SEARCH) begin
                            cand_tof_q <= tof_cnt_q;
                            peak_max_q <= mag;
                        end else begin
                            peak_max_q <= peak_d;
                        end
                        run_cnt_q <= 4'(CONFIRM_N);
                        win_cnt_q <= PW_LAST;
                        state_q   <= PEAK;
                    end else if (at_timeout) begin
                        echo_tof_q  <= 20'hFFFFF;
                        echo_peak_q <= '0;
                        timeout_q   <= 1'b1;
                        state_q     <= DONE;
                    end else if (state_q == SEARCH) begin
                        if (qual) begin
                            cand_tof_q <= tof_cnt_q;
                            run_cnt_q  <= 4'd1;
                            peak_max_q <= mag;
                            state_q    <= CONFIRM;
                        end
                    end else if (qual) begin
                        run_cnt_q  <= run_cnt_q + 4'd1;
                        peak_max_q <= peak_d;
                    end else if (bus.adc_valid) begin
                        // A valid miss breaks the run; invalid cycles are transparent.
                        run_cnt_q  <= '0;
                        peak_max_q <= '0;
                        state_q    <= SEARCH;
                    end
                end

                PEAK: begin
                    peak_max_q <= peak_d;
                    if (win_cnt_q == '0) begin
                        echo_tof_q  <= cand_tof_q;
                        echo_peak_q <= 18'(peak_d);
                        timeout_q   <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        win_cnt_q <= win_cnt_q - 1'b1;
                    end
                end

                DONE: begin
                    if (!bus.tx_busy) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.echo_tof     = echo_tof_q;
    assign bus.echo_peak    = echo_peak_q;
    assign bus.timeout_flag = timeout_q;
    assign bus.busy         = busy_q;
    // Strobe fires in the first DONE cycle the transmitter is free, so it has to
    // see tx_busy of that same cycle rather than a registered copy.
    assign bus.processing_done = (state_q == DONE) && !bus.tx_busy;
endmodule
